// File: rtl/vdp2_vram_bank.sv
// VDP2 VRAM bank arbiter: dot-slot scheduled VDP2 reads, queued CPU writes, pending CPU reads.
// Define VDP2_VRAM_RDFWD_EN to forward CPU reads from full-word write-FIFO entries.
module vdp2_vram_bank (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        DOT_CE,
  input  logic        CPU_SLOT,
  input  logic [18:0] RA_A,
  output logic [15:0] RA_DO,
  input  logic [18:0] CPU_A,
  input  logic [15:0] CPU_D,
  input  logic [1:0]  CPU_BE,
  input  logic        CPU_WE,
  input  logic        CPU_RD,
  output logic        CPU_BUSY,
  output logic [15:0] CPU_DO,
  output logic        CPU_RDY,
  output logic        WR_OVF,
  output logic [18:0] MEM_A,
  output logic [15:0] MEM_D,
  output logic [1:0]  MEM_BE,
  output logic        MEM_WE,
  input  logic [15:0] MEM_Q
);
  typedef enum logic [1:0] {IDLE, VRD, CWR, CRD} state_t;
  state_t state_q, state_d;

  logic [18:0] fifo_a_q  [4];
  logic [15:0] fifo_d_q  [4];
  logic [1:0]  fifo_be_q [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        push, pop, rd_acc, fwd_hit;
  logic [15:0] fwd_data;
  logic        pend_q, pend_d;
  logic [18:0] pend_a_q, pend_a_d;
  logic        cap_vrd_q, cap_vrd_d, cap_crd_q, cap_crd_d;
  logic [18:0] mem_a_q, mem_a_d;
  logic [15:0] mem_d_q, mem_d_d;
  logic [1:0]  mem_be_q, mem_be_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] ra_do_q, ra_do_d, cpu_do_q, cpu_do_d;
  logic        cpu_rdy_q, cpu_rdy_d, busy_q, busy_d, ovf_q, ovf_d;
`ifdef VDP2_VRAM_RDFWD_EN
  logic [1:0]  fidx;
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (DOT_CE) begin
        if (!CPU_SLOT)         state_d = VRD;
        else if (cnt_q != 3'd0) state_d = CWR;
        else if (pend_q)        state_d = CRD;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory bus is set up on the DOT_CE edge; the access state itself schedules the follow-up.
  always_comb begin
    mem_a_d   = mem_a_q;
    mem_d_d   = mem_d_q;
    mem_be_d  = mem_be_q;
    mem_we_d  = 1'b0;
    pop       = 1'b0;
    cap_vrd_d = 1'b0;
    cap_crd_d = 1'b0;
    case (state_q)
      IDLE: begin
        case (state_d)
          VRD: mem_a_d = RA_A;
          CWR: begin
            mem_a_d  = fifo_a_q[rd_ptr_q];
            mem_d_d  = fifo_d_q[rd_ptr_q];
            mem_be_d = fifo_be_q[rd_ptr_q];
            mem_we_d = 1'b1;
          end
          CRD: mem_a_d = pend_a_q;
          default: ;
        endcase
      end
      VRD: cap_vrd_d = 1'b1;
      CWR: pop       = 1'b1;
      CRD: cap_crd_d = 1'b1;
      default: ;
    endcase
  end

  // Scan oldest to newest so the last hit is the newest matching entry.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = 16'h0;
`ifdef VDP2_VRAM_RDFWD_EN
    fidx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      fidx = rd_ptr_q + 2'(i);
      if (i < int'(cnt_q) && fifo_be_q[fidx] == 2'b11 && fifo_a_q[fidx] == CPU_A) begin
        fwd_hit  = 1'b1;
        fwd_data = fifo_d_q[fidx];
      end
    end
`endif
  end

  always_comb begin
    push     = CPU_WE && (cnt_q != 3'd4);
    rd_acc   = CPU_RD && !pend_q;
    cnt_d    = cnt_q + 3'(push) - 3'(pop);
    wr_ptr_d = wr_ptr_q + 2'(push);
    rd_ptr_d = rd_ptr_q + 2'(pop);
    ovf_d    = ovf_q | (CPU_WE && (cnt_q == 3'd4));
    pend_d   = pend_q;
    pend_a_d = pend_a_q;
    if (cap_crd_q) pend_d = 1'b0;
    if (rd_acc && !fwd_hit) begin
      pend_d   = 1'b1;
      pend_a_d = CPU_A;
    end
    busy_d    = (cnt_d == 3'd4) | pend_d;
    ra_do_d   = cap_vrd_q ? MEM_Q : ra_do_q;
    cpu_do_d  = cpu_do_q;
    if (cap_crd_q)             cpu_do_d = MEM_Q;
    else if (rd_acc && fwd_hit) cpu_do_d = fwd_data;
    cpu_rdy_d = cap_crd_q | (rd_acc & fwd_hit);
  end

  always_ff @(posedge CLK) begin
    if (RST_N && push) begin
      fifo_a_q[wr_ptr_q]  <= CPU_A;
      fifo_d_q[wr_ptr_q]  <= CPU_D;
      fifo_be_q[wr_ptr_q] <= CPU_BE;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr_q  <= 2'd0;
      rd_ptr_q  <= 2'd0;
      cnt_q     <= 3'd0;
      pend_q    <= 1'b0;
      pend_a_q  <= 19'd0;
      cap_vrd_q <= 1'b0;
      cap_crd_q <= 1'b0;
      mem_a_q   <= 19'd0;
      mem_d_q   <= 16'd0;
      mem_be_q  <= 2'd0;
      mem_we_q  <= 1'b0;
      ra_do_q   <= 16'd0;
      cpu_do_q  <= 16'd0;
      cpu_rdy_q <= 1'b0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pend_a_q  <= pend_a_d;
      cap_vrd_q <= cap_vrd_d;
      cap_crd_q <= cap_crd_d;
      mem_a_q   <= mem_a_d;
      mem_d_q   <= mem_d_d;
      mem_be_q  <= mem_be_d;
      mem_we_q  <= mem_we_d;
      ra_do_q   <= ra_do_d;
      cpu_do_q  <= cpu_do_d;
      cpu_rdy_q <= cpu_rdy_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
    end
  end

  assign RA_DO    = ra_do_q;
  assign CPU_DO   = cpu_do_q;
  assign CPU_RDY  = cpu_rdy_q;
  assign CPU_BUSY = busy_q;
  assign WR_OVF   = ovf_q;
  assign MEM_A    = mem_a_q;
  assign MEM_D    = mem_d_q;
  assign MEM_BE   = mem_be_q;
  assign MEM_WE   = mem_we_q;
endmodule

// File: tb/tb_vdp2_vram_bank.sv
// Scoreboard bench for vdp2_vram_bank: stimulus queues expected RAM writes, RA_DO captures
// and CPU read data; a negedge monitor pops and compares as the DUT presents them.
module tb_vdp2_vram_bank;
`ifdef VDP2_VRAM_RDFWD_EN
  localparam int FWD = 1;
`else
  localparam int FWD = 0;
`endif

  logic        CLK = 1'b0;
  logic        RST_N, DOT_CE, CPU_SLOT, CPU_WE, CPU_RD;
  logic [18:0] RA_A, CPU_A;
  logic [15:0] CPU_D;
  logic [1:0]  CPU_BE;
  logic [15:0] RA_DO, CPU_DO, MEM_D;
  logic        CPU_BUSY, CPU_RDY, WR_OVF, MEM_WE;
  logic [18:0] MEM_A;
  logic [1:0]  MEM_BE;
  logic [15:0] MEM_Q;

  always #5 CLK = ~CLK;

  vdp2_vram_bank dut (
    .CLK(CLK), .RST_N(RST_N), .DOT_CE(DOT_CE), .CPU_SLOT(CPU_SLOT), .RA_A(RA_A),
    .RA_DO(RA_DO), .CPU_A(CPU_A), .CPU_D(CPU_D), .CPU_BE(CPU_BE), .CPU_WE(CPU_WE),
    .CPU_RD(CPU_RD), .CPU_BUSY(CPU_BUSY), .CPU_DO(CPU_DO), .CPU_RDY(CPU_RDY),
    .WR_OVF(WR_OVF), .MEM_A(MEM_A), .MEM_D(MEM_D), .MEM_BE(MEM_BE), .MEM_WE(MEM_WE),
    .MEM_Q(MEM_Q)
  );

  // Synchronous RAM model, preloaded on the first edge
  logic [15:0] ram [1024];
  logic        ram_init = 1'b0;
  always @(posedge CLK) begin
    if (!ram_init) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 16'h0;
      ram[10'h010] <= 16'hBEEF;
      ram[10'h020] <= 16'h5A5A;
      ram_init     <= 1'b1;
      MEM_Q        <= 16'h0;
    end else begin
      if (MEM_WE && MEM_BE[1]) ram[MEM_A[9:0]][15:8] <= MEM_D[15:8];
      if (MEM_WE && MEM_BE[0]) ram[MEM_A[9:0]][7:0]  <= MEM_D[7:0];
      MEM_Q <= ram[MEM_A[9:0]];
    end
  end

  int nchecks = 0;
  int nerr    = 0;
  int rdy_seen = 0;
  logic [15:0] exp_ra [$];
  logic [15:0] exp_cpu [$];
  logic [36:0] exp_wr [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    nchecks++;
    nerr++;
    $display("FAIL %s: unexpected output %0h, expected none", name, act);
  endtask

  // Monitor: RA_DO is due two edges after a sampled VDP2 dot slot
  logic [2:0] vrd_pipe = 3'b0;
  always @(posedge CLK) vrd_pipe <= {vrd_pipe[1:0], RST_N && DOT_CE && !CPU_SLOT};

  always @(negedge CLK) begin
    if (vrd_pipe[2]) begin
      if (exp_ra.size() == 0) unexpected("ra_do", RA_DO);
      else chk("ra_do", RA_DO, exp_ra.pop_front());
    end
    if (MEM_WE) begin
      if (exp_wr.size() == 0) unexpected("mem_wr", {MEM_A, MEM_D, MEM_BE});
      else chk("mem_wr", {MEM_A, MEM_D, MEM_BE}, exp_wr.pop_front());
    end
    if (CPU_RDY) begin
      rdy_seen++;
      if (exp_cpu.size() == 0) unexpected("cpu_do", CPU_DO);
      else chk("cpu_do", CPU_DO, exp_cpu.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic dot(input logic slot);
    DOT_CE = 1'b1; CPU_SLOT = slot;
    tick();
    DOT_CE = 1'b0; CPU_SLOT = 1'b0;
    repeat (3) tick();
  endtask

  task automatic wr(input logic [18:0] a, input logic [15:0] d, input logic [1:0] be);
    CPU_WE = 1'b1; CPU_A = a; CPU_D = d; CPU_BE = be;
    tick();
    CPU_WE = 1'b0;
  endtask

  task automatic rd(input logic [18:0] a);
    CPU_RD = 1'b1; CPU_A = a;
    tick();
    CPU_RD = 1'b0;
  endtask

  task automatic reset_dut();
    RST_N = 1'b0;
    repeat (3) tick();
    RST_N = 1'b1;
    tick();
  endtask

  logic [15:0] wd [5] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
  logic [1:0]  wb [5] = '{2'b11, 2'b01, 2'b10, 2'b11, 2'b11};
  int base;

  initial begin
    RST_N = 1'b0; DOT_CE = 1'b0; CPU_SLOT = 1'b0; RA_A = '0;
    CPU_A = '0; CPU_D = '0; CPU_BE = '0; CPU_WE = 1'b0; CPU_RD = 1'b0;
    repeat (3) tick();
    chk("reset_outs", {RA_DO, CPU_DO, CPU_RDY, CPU_BUSY, WR_OVF, MEM_A, MEM_D, MEM_BE, MEM_WE}, '0);
    RST_N = 1'b1;
    tick();

    // VDP2 slot reads
    exp_ra.push_back(16'hBEEF); RA_A = 19'h00010; dot(1'b0);
    exp_ra.push_back(16'h5A5A); RA_A = 19'h00020; dot(1'b0);

    // Fill the FIFO, overflow on the 5th write, drain in order
    for (int i = 0; i < 5; i++) begin
      if (i == 3) chk("busy_3_entries", CPU_BUSY, 1'b0);
      if (i == 4) chk("ovf_before_drop", WR_OVF, 1'b0);
      wr(19'h200 + 19'(i), wd[i], wb[i]);
      if (i < 4) exp_wr.push_back({19'h200 + 19'(i), wd[i], wb[i]});
    end
    chk("busy_full", CPU_BUSY, 1'b1);
    chk("ovf_after_drop", WR_OVF, 1'b1);
    repeat (4) dot(1'b1);
    chk("busy_drained", CPU_BUSY, 1'b0);
    exp_ra.push_back(16'h3300); RA_A = 19'h202; dot(1'b0);
    exp_ra.push_back(16'h0022); RA_A = 19'h201; dot(1'b0);
    dot(1'b1);
    chk("ra_do_idle_slot", RA_DO, 16'h0022);

    // Full-word write then read of the same address
    base = rdy_seen;
    wr(19'h100, 16'h1234, 2'b11);
    exp_wr.push_back({19'h100, 16'h1234, 2'b11});
    exp_cpu.push_back(16'h1234);
    rd(19'h100);
    tick();
    chk("busy_rd_full", CPU_BUSY, (FWD != 0) ? 1'b0 : 1'b1);
    chk("rdy_before_slot", rdy_seen, base + FWD);
    dot(1'b1);
    chk("rdy_after_cwr", rdy_seen, base + FWD);
    dot(1'b1);
    chk("rdy_after_crd", rdy_seen, base + 1);
    chk("busy_after_rd", CPU_BUSY, 1'b0);

    // Partial-byte write never forwards
    base = rdy_seen;
    wr(19'h180, 16'hABCD, 2'b01);
    exp_wr.push_back({19'h180, 16'hABCD, 2'b01});
    exp_cpu.push_back(16'h00CD);
    rd(19'h180);
    tick();
    chk("busy_rd_partial", CPU_BUSY, 1'b1);
    dot(1'b1);
    chk("rdy_partial_cwr", rdy_seen, base);
    dot(1'b1);
    chk("rdy_partial_crd", rdy_seen, base + 1);

    // Stale entries must vanish with reset; then write coincident with a pop from full
    wr(19'h3A0, 16'hDEAD, 2'b11);
    wr(19'h3A1, 16'hDEAD, 2'b11);
    reset_dut();
    chk("ovf_cleared", WR_OVF, 1'b0);
    chk("busy_cleared", CPU_BUSY, 1'b0);
    for (int i = 0; i < 4; i++) begin
      wr(19'h300 + 19'(i), 16'hA000 + 16'(i), 2'b11);
      exp_wr.push_back({19'h300 + 19'(i), 16'hA000 + 16'(i), 2'b11});
    end
    chk("busy_full2", CPU_BUSY, 1'b1);
    DOT_CE = 1'b1; CPU_SLOT = 1'b1;
    tick();
    DOT_CE = 1'b0; CPU_SLOT = 1'b0;
    CPU_WE = 1'b1; CPU_A = 19'h3FF; CPU_D = 16'hFFFF; CPU_BE = 2'b11;
    tick();
    CPU_WE = 1'b0;
    chk("ovf_on_pop", WR_OVF, 1'b1);
    repeat (2) tick();
    repeat (4) dot(1'b1);
    chk("busy_drained2", CPU_BUSY, 1'b0);
    exp_ra.push_back(16'h0000); RA_A = 19'h3FF; dot(1'b0);

    // Reset right after a CPU read slot is issued
    base = rdy_seen;
    rd(19'h010);
    tick();
    chk("busy_pending", CPU_BUSY, 1'b1);
    DOT_CE = 1'b1; CPU_SLOT = 1'b1;
    tick();
    DOT_CE = 1'b0; CPU_SLOT = 1'b0;
    RST_N = 1'b0;
    repeat (2) tick();
    chk("abort_outs", {RA_DO, CPU_DO, CPU_RDY, CPU_BUSY, WR_OVF, MEM_A, MEM_D, MEM_BE, MEM_WE}, '0);
    RST_N = 1'b1;
    repeat (4) tick();
    chk("abort_no_rdy", rdy_seen, base);
    chk("abort_busy", CPU_BUSY, 1'b0);
    repeat (2) dot(1'b1);
    chk("abort_no_rdy_late", rdy_seen, base);

    chk("ra_queue_empty", exp_ra.size(), 0);
    chk("wr_queue_empty", exp_wr.size(), 0);
    chk("cpu_queue_empty", exp_cpu.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule
